// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the seven-segment scan driver.
//   - GLYPH_* : logical segment patterns (1 = lit), bit 6 = a ... bit 0 = g
//   - slot_state_t : phase of the current digit slot (dark gap / lit)
// ---------------------------------------------------------------------------
package seven_seg_pkg;

   localparam logic [6:0] GLYPH_0    = 7'b1111110;
   localparam logic [6:0] GLYPH_1    = 7'b0110000;
   localparam logic [6:0] GLYPH_2    = 7'b1101101;
   localparam logic [6:0] GLYPH_3    = 7'b1111001;
   localparam logic [6:0] GLYPH_4    = 7'b0110011;
   localparam logic [6:0] GLYPH_5    = 7'b1011011;
   localparam logic [6:0] GLYPH_6    = 7'b1011111;
   localparam logic [6:0] GLYPH_7    = 7'b1110000;
   localparam logic [6:0] GLYPH_8    = 7'b1111111;
   localparam logic [6:0] GLYPH_9    = 7'b1111011;
   localparam logic [6:0] GLYPH_A    = 7'b1110111;
   localparam logic [6:0] GLYPH_B    = 7'b0011111;
   localparam logic [6:0] GLYPH_C    = 7'b1001110;
   localparam logic [6:0] GLYPH_D    = 7'b0111101;
   localparam logic [6:0] GLYPH_E    = 7'b1001111;
   localparam logic [6:0] GLYPH_F    = 7'b1000111;
   localparam logic [6:0] GLYPH_DASH = 7'b0000001;
   localparam logic [6:0] GLYPH_OFF  = 7'b0000000;

   typedef enum logic [0:0] {
      ST_DEAD = 1'b0,
      ST_ON   = 1'b1
   } slot_state_t;

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver_if
// Bundle between the time-keeping logic and the display scan driver.
//   load      : 1-cycle capture strobe for digits/dp/blank
//   digits    : packed nibbles, digit 0 in bits [3:0]
//   dp, blank : per-digit decimal point request / forced dark
//   hex_mode  : codes 10-15 as A..F (1) or dash (0)
//   lz_blank  : leading-zero suppression enable
//   seg       : segments a..g (bit 6 = a), pin polarity
//   seg_dp    : decimal point segment, pin polarity
//   an        : digit enables, pin polarity
//   slot_tick : pulse on the last cycle of each digit slot
// master = display client, slave = scan driver.
// ---------------------------------------------------------------------------
interface seven_seg_scan_driver_if #(
   parameter int N_DIGITS = 4
);
   logic                    load;
   logic [4*N_DIGITS-1:0]   digits;
   logic [N_DIGITS-1:0]     dp;
   logic [N_DIGITS-1:0]     blank;
   logic                    hex_mode;
   logic                    lz_blank;
   logic [6:0]              seg;
   logic                    seg_dp;
   logic [N_DIGITS-1:0]     an;
   logic                    slot_tick;

   modport master (
      output load, digits, dp, blank, hex_mode, lz_blank,
      input  seg, seg_dp, an, slot_tick
   );

   modport slave (
      input  load, digits, dp, blank, hex_mode, lz_blank,
      output seg, seg_dp, an, slot_tick
   );
endinterface

// File: rtl/seven_seg_glyph.sv
// ---------------------------------------------------------------------------
// seven_seg_glyph
// Combinational nibble decoder, polarity-free (1 = segment lit).
//   nibble   in  4  code to show
//   hex_mode in  1  1: 10-15 as A,b,C,d,E,F; 0: 10-15 as dash
//   glyph    out 7  abcdefg, bit 6 = a
// ---------------------------------------------------------------------------
module seven_seg_glyph
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex_mode,
   output logic [6:0] glyph
);

   always_comb begin
      glyph = GLYPH_OFF;
      case (nibble)
         4'h0: glyph = GLYPH_0;
         4'h1: glyph = GLYPH_1;
         4'h2: glyph = GLYPH_2;
         4'h3: glyph = GLYPH_3;
         4'h4: glyph = GLYPH_4;
         4'h5: glyph = GLYPH_5;
         4'h6: glyph = GLYPH_6;
         4'h7: glyph = GLYPH_7;
         4'h8: glyph = GLYPH_8;
         4'h9: glyph = GLYPH_9;
         4'hA: glyph = hex_mode ? GLYPH_A : GLYPH_DASH;
         4'hB: glyph = hex_mode ? GLYPH_B : GLYPH_DASH;
         4'hC: glyph = hex_mode ? GLYPH_C : GLYPH_DASH;
         4'hD: glyph = hex_mode ? GLYPH_D : GLYPH_DASH;
         4'hE: glyph = hex_mode ? GLYPH_E : GLYPH_DASH;
         4'hF: glyph = hex_mode ? GLYPH_F : GLYPH_DASH;
         default: glyph = GLYPH_OFF;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
// Time-multiplexed N-digit seven-segment driver. Each digit owns a slot of
// REFRESH_DIV cycles; the first DEAD_CYCLES of a slot keep every anode off
// to avoid ghosting, the rest light the current digit.
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   bus   slave modport of seven_seg_scan_driver_if (load/digits/dp/blank/
//         hex_mode/lz_blank in; seg/seg_dp/an/slot_tick out)
// All outputs are registered and reflect the prescaler/index of the
// previous cycle.
// ---------------------------------------------------------------------------
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int DEAD_CYCLES    = 500,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seven_seg_scan_driver_if.slave bus
);

   localparam int PS_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int DIG_W = 4 * N_DIGITS;

   localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(REFRESH_DIV - 1);
   localparam logic [PS_W-1:0]     PS_DEAD  = PS_W'(DEAD_CYCLES);
   localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
   localparam logic [6:0]          SEG_POL  = {7{SEG_ACTIVE_LOW}};
   localparam logic [N_DIGITS-1:0] AN_POL   = {N_DIGITS{AN_ACTIVE_LOW}};

   // scan counters
   logic [PS_W-1:0]     ps_p0;
   logic [IDX_W-1:0]    idx_p0;

   // shadow (written by load) and display (copied once per slot)
   logic [DIG_W-1:0]    sh_digits;
   logic [N_DIGITS-1:0] sh_dp;
   logic [N_DIGITS-1:0] sh_blank;
   logic [DIG_W-1:0]    dsp_digits;
   logic [N_DIGITS-1:0] dsp_dp;
   logic [N_DIGITS-1:0] dsp_blank;

   // registered pin outputs
   logic [6:0]          seg_p1;
   logic                seg_dp_p1;
   logic [N_DIGITS-1:0] an_p1;
   logic                slot_tick_p1;

   logic                slot_first;
   logic                slot_last;
   slot_state_t         st;
   logic [DIG_W-1:0]    eff_digits;
   logic [N_DIGITS-1:0] eff_dp;
   logic [N_DIGITS-1:0] eff_blank;
   logic [N_DIGITS-1:0] lz_mask;
   logic                zero_run;
   logic [3:0]          nibble;
   logic [6:0]          glyph;
   logic                dig_blank;
   logic [N_DIGITS-1:0] an_sel;
   logic [6:0]          seg_nx;
   logic                dp_nx;
   logic [N_DIGITS-1:0] an_nx;

   assign slot_first = (ps_p0 == '0);
   assign slot_last  = (ps_p0 == PS_LAST);

   always_comb begin
      st = ST_ON;
      if ((DEAD_CYCLES > 0) && (ps_p0 < PS_DEAD)) begin
         st = ST_DEAD;
      end
   end

   // On the first cycle of a slot the display register is being refreshed,
   // so decode from the value it is about to take (shadow, or the word being
   // loaded this very cycle). This keeps DEAD_CYCLES=0 and the load bypass
   // consistent with what the display register holds for the rest of the slot.
   always_comb begin
      eff_digits = dsp_digits;
      eff_dp     = dsp_dp;
      eff_blank  = dsp_blank;
      if (slot_first) begin
         if (bus.load) begin
            eff_digits = bus.digits;
            eff_dp     = bus.dp;
            eff_blank  = bus.blank;
         end else begin
            eff_digits = sh_digits;
            eff_dp     = sh_dp;
            eff_blank  = sh_blank;
         end
      end
   end

   // Leading-zero mask: walk from the most significant digit down while the
   // nibbles stay zero. Digit 0 is always shown.
   always_comb begin
      zero_run = 1'b1;
      lz_mask  = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (eff_digits[4*i +: 4] == 4'h0);
         if (i != 0) begin
            lz_mask[i] = bus.lz_blank & zero_run;
         end
      end
   end

   assign nibble    = eff_digits[{idx_p0, 2'b00} +: 4];
   assign dig_blank = eff_blank[idx_p0] | lz_mask[idx_p0];
   assign an_sel    = N_DIGITS'(1) << idx_p0;

   seven_seg_glyph u_glyph (
      .nibble   (nibble),
      .hex_mode (bus.hex_mode),
      .glyph    (glyph)
   );

   // Logical outputs. A blanked digit keeps its anode so every slot draws the
   // same duty cycle; dp is only suppressed by the explicit blank request.
   always_comb begin
      seg_nx = GLYPH_OFF;
      dp_nx  = 1'b0;
      an_nx  = '0;
      if (st == ST_ON) begin
         an_nx = an_sel;
         if (!dig_blank) begin
            seg_nx = glyph;
         end
         if (!eff_blank[idx_p0]) begin
            dp_nx = eff_dp[idx_p0];
         end
      end
   end

   // stage p0 -> p1: counters, shadow/display registers and pin registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ps_p0        <= '0;
         idx_p0       <= '0;
         sh_digits    <= '0;
         sh_dp        <= '0;
         sh_blank     <= '0;
         dsp_digits   <= '0;
         dsp_dp       <= '0;
         dsp_blank    <= '0;
         seg_p1       <= SEG_POL;
         seg_dp_p1    <= SEG_ACTIVE_LOW;
         an_p1        <= AN_POL;
         slot_tick_p1 <= 1'b0;
      end else begin
         if (bus.load) begin
            sh_digits <= bus.digits;
            sh_dp     <= bus.dp;
            sh_blank  <= bus.blank;
         end
         if (slot_first) begin
            dsp_digits <= eff_digits;
            dsp_dp     <= eff_dp;
            dsp_blank  <= eff_blank;
         end
         if (slot_last) begin
            ps_p0  <= '0;
            idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
         end else begin
            ps_p0  <= ps_p0 + 1'b1;
         end
         seg_p1       <= seg_nx ^ SEG_POL;
         seg_dp_p1    <= dp_nx ^ SEG_ACTIVE_LOW;
         an_p1        <= an_nx ^ AN_POL;
         slot_tick_p1 <= slot_last;
      end
   end

   assign bus.seg       = seg_p1;
   assign bus.seg_dp    = seg_dp_p1;
   assign bus.an        = an_p1;
   assign bus.slot_tick = slot_tick_p1;

endmodule
